// File: rtl/mem_pkg.sv
// Shared types and boot image for the mem_ctrl slice. The image is used only when
// MEM_CTRL_BOOT_INIT_EN is defined.
package mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned BOOT_LEN = 31;

  // Instruction word layout: op[15:13] rd[12:10] rs[9:7] imm[6:0].
  // op: 0 LDI, 1 SHL, 2 SUB (rd = imm - rs), 3 STI (Mem[rs] = imm), 4 LD, 5 ADDI.
  // The final entry is the data word 30 = 69 that the STI/LD pair operates on.
  localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
    16'h040F,  // LDI  R1, 15
    16'h041E,  // LDI  R1, 30
    16'h2483,  // SHL  R1, R1, 3   -> 240
    16'h4880,  // SUB  R2, 0 - R1
    16'h0C1E,  // LDI  R3, 30
    16'h61C5,  // STI  Mem[R3], 69
    16'h9180,  // LD   R4, Mem[R3]
    16'hB200,  // ADDI R4, R4, 0
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0045   // word 30 = 69
  };

  function automatic logic [15:0] boot_word(input int unsigned idx);
    logic [4:0] idx5;
    idx5 = idx[4:0];
    return (idx < BOOT_LEN) ? BOOT_IMAGE[idx5] : 16'h0000;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bus between a requester (master) and mem_ctrl (slave).
interface mem_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) ();
  localparam int unsigned BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_array.sv
// Single-port byte-enabled storage with a registered (synchronous) read port.
// Contents are never reset.
module mem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic [DATA_W-1:0]     rdata_o
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read data only changes on an enabled read, so it holds while a response stalls.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: request accept, range check, 1/2-cycle read pipeline, response
// backpressure and optional boot fill (MEM_CTRL_BOOT_INIT_EN).
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic      CLK,
  input  logic      reset_n,
  mem_ctrl_if.slave bus,
  output logic      init_busy
);
  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned AW   = $clog2(DEPTH);
`ifdef MEM_CTRL_BOOT_INIT_EN
  localparam state_e RESET_ST = ST_INIT;
`else
  localparam state_e RESET_ST = ST_RUN;
`endif

  state_e            state_q, state_d;
  logic [AW-1:0]     fill_q, fill_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_err_q, s1_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  logic              in_range, ready, accept, rd_acc, done, done_err;
  logic              mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [BE_W-1:0]   mem_be;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = AW'(bus.req_addr);
    mem_wdata   = bus.req_wdata;
    mem_be      = bus.req_be;

    in_range = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
    ready    = (state_q == ST_RUN) && !s1_valid_q && !(rsp_valid_q && !bus.rsp_ready);
    accept   = bus.req_valid && ready;
    rd_acc   = accept && !bus.req_we;

    // With RD_LAT=2 a read sits one cycle in stage 1 before completing.
    s1_valid_d = (RD_LAT == 2) && rd_acc;
    s1_err_d   = (RD_LAT == 2) && rd_acc && !in_range;
    done       = s1_valid_q || ((RD_LAT == 1) && rd_acc);
    done_err   = s1_valid_q ? s1_err_q : !in_range;

    case (state_q)
      ST_INIT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = fill_q;
        mem_wdata = DATA_W'(boot_word(32'(fill_q)));
        mem_be    = '1;
        if (fill_q == AW'(DEPTH - 1)) state_d = ST_RUN;
        else                          fill_d  = fill_q + 1'b1;
      end
      ST_RUN: begin
        mem_en = accept && in_range;
        mem_we = bus.req_we;
      end
      default: state_d = RESET_ST;
    endcase

    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    if (done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = done_err;
    end else if (bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_ST;
      fill_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      s1_valid_q  <= s1_valid_d;
      s1_err_q    <= s1_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i   (CLK),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .be_i    (mem_be),
    .rdata_o (mem_rdata)
  );

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)        rdata_q <= '0;
        else if (s1_valid_q) rdata_q <= s1_err_q ? '0 : mem_rdata;
      end
      assign bus.rsp_rdata = rdata_q;
    end else begin : g_lat1
      // Array read register is the data stage; zeroed for errors and when idle.
      assign bus.rsp_rdata = (rsp_valid_q && !rsp_err_q) ? mem_rdata : '0;
    end
  endgenerate

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef MEM_CTRL_BOOT_INIT_EN
  assign init_busy = (state_q == ST_INIT);
`else
  assign init_busy = 1'b0;
`endif
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one RD_LAT=1 and one RD_LAT=2 instance on a shared
// clock/reset. Boot-image checks are active when MEM_CTRL_BOOT_INIT_EN is defined.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic init_busy1, init_busy2;
  logic seen;
  int   n_assert = 0;
  int   n_fail   = 0;

  mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();
  mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus2 ();

  mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(1)) u_dut1 (
    .CLK(clk), .reset_n(reset_n), .bus(bus1), .init_busy(init_busy1)
  );
  mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(2)) u_dut2 (
    .CLK(clk), .reset_n(reset_n), .bus(bus2), .init_busy(init_busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_boot(input string tag);
    int n = 0;
    while ((init_busy1 !== 1'b0 || init_busy2 !== 1'b0) && n < 1100) begin
      tick();
      n++;
    end
    chk(tag, {30'd0, init_busy1, init_busy2}, 32'd0);
`ifdef MEM_CTRL_BOOT_INIT_EN
    chk({tag, "_cycles"}, n, 32'd1024);
`endif
  endtask

  task automatic wr1(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1;
    bus1.req_addr = a; bus1.req_wdata = d; bus1.req_be = be;
    tick();
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0;
  endtask

  task automatic wr2(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b1;
    bus2.req_addr = a; bus2.req_wdata = d; bus2.req_be = be;
    tick();
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0;
  endtask

  task automatic rd1(input string tag, input logic [15:0] a, input logic [15:0] ed, input logic ee);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = a;
    tick();
    bus1.req_valid = 1'b0;
    #1;
    chk({tag, "_v"}, bus1.rsp_valid, 32'd1);
    chk({tag, "_d"}, bus1.rsp_rdata, ed);
    chk({tag, "_e"}, bus1.rsp_err, ee);
  endtask

  task automatic rd2(input string tag, input logic [15:0] a, input logic [15:0] ed, input logic ee);
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = a;
    #1;
    chk({tag, "_rdy_t"}, bus2.req_ready, 32'd1);
    tick();
    bus2.req_valid = 1'b0;
    #1;
    chk({tag, "_rdy_t1"}, bus2.req_ready, 32'd0);
    chk({tag, "_v_t1"}, bus2.rsp_valid, 32'd0);
    tick();
    #1;
    chk({tag, "_v_t2"}, bus2.rsp_valid, 32'd1);
    chk({tag, "_d_t2"}, bus2.rsp_rdata, ed);
    chk({tag, "_e_t2"}, bus2.rsp_err, ee);
    tick();
    #1;
    chk({tag, "_v_clr"}, bus2.rsp_valid, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0; bus1.req_be = '0; bus1.rsp_ready = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0;
    bus2.req_wdata = '0; bus2.req_be = '0; bus2.rsp_ready = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_v1", bus1.rsp_valid, 32'd0);
    chk("rst_e1", bus1.rsp_err, 32'd0);
    chk("rst_d1", bus1.rsp_rdata, 32'd0);
    chk("rst_v2", bus2.rsp_valid, 32'd0);
    chk("rst_d2", bus2.rsp_rdata, 32'd0);

    tick();
    reset_n = 1'b1;
    #1;
`ifdef MEM_CTRL_BOOT_INIT_EN
    chk("boot_busy", init_busy1, 32'd1);
    chk("boot_rdy", bus1.req_ready, 32'd0);
`else
    chk("nb_busy", init_busy1, 32'd0);
    chk("nb_rdy", bus1.req_ready, 32'd1);
`endif
    wait_boot("boot_done");
`ifdef MEM_CTRL_BOOT_INIT_EN
    rd1("boot0", 16'd0, 16'h040F, 1'b0);
    rd1("boot30", 16'd30, 16'h0045, 1'b0);
    rd1("boot1000", 16'd1000, 16'h0000, 1'b0);
`endif

    // Byte-enable merge
    wr1(16'd5, 16'h1234, 2'b11);
    wr1(16'd5, 16'hABCD, 2'b01);
    rd1("be_merge", 16'd5, 16'h12CD, 1'b0);

    // Read on the cycle right after a write
    wr1(16'd7, 16'h5A5A, 2'b11);
    rd1("wr_then_rd", 16'd7, 16'h5A5A, 1'b0);

    // Back-to-back reads at one per cycle
    wr1(16'd8, 16'h1111, 2'b11);
    wr1(16'd9, 16'h2222, 2'b11);
    wr1(16'd10, 16'h3333, 2'b11);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'd8;
    tick();
    bus1.req_addr = 16'd9;
    #1;
    chk("b2b_v0", bus1.rsp_valid, 32'd1);
    chk("b2b_d0", bus1.rsp_rdata, 32'h1111);
    chk("b2b_rdy0", bus1.req_ready, 32'd1);
    tick();
    bus1.req_addr = 16'd10;
    #1;
    chk("b2b_d1", bus1.rsp_rdata, 32'h2222);
    tick();
    bus1.req_valid = 1'b0;
    #1;
    chk("b2b_v2", bus1.rsp_valid, 32'd1);
    chk("b2b_d2", bus1.rsp_rdata, 32'h3333);
    tick();
    #1;
    chk("b2b_idle", bus1.rsp_valid, 32'd0);

    // Out-of-range accesses
    rd1("oor_rd", 16'd1024, 16'h0000, 1'b1);
    rd1("oor_max", 16'hFFFF, 16'h0000, 1'b1);
    wr1(16'd0, 16'h7E57, 2'b11);
    wr1(16'd1024, 16'hFFFF, 2'b11);
    rd1("oor_wr", 16'd0, 16'h7E57, 1'b0);

    // Response backpressure with a second read waiting
    wr1(16'd12, 16'hBEEF, 2'b11);
    bus1.rsp_ready = 1'b0;
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_addr = 16'd12;
    tick();
    bus1.req_addr = 16'd5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("bp_v%0d", i), bus1.rsp_valid, 32'd1);
      chk($sformatf("bp_d%0d", i), bus1.rsp_rdata, 32'hBEEF);
      chk($sformatf("bp_rdy%0d", i), bus1.req_ready, 32'd0);
      tick();
    end
    bus1.rsp_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", bus1.req_ready, 32'd1);
    chk("bp_rel_d", bus1.rsp_rdata, 32'hBEEF);
    tick();
    bus1.req_valid = 1'b0;
    #1;
    chk("bp_next_v", bus1.rsp_valid, 32'd1);
    chk("bp_next_d", bus1.rsp_rdata, 32'h12CD);
    tick();

    // Two-cycle read latency instance
    wr2(16'd30, 16'h0045, 2'b11);
    rd2("l2_rd30", 16'd30, 16'h0045, 1'b0);
    rd2("l2_oor", 16'd1024, 16'h0000, 1'b1);

    // Reset while a response is stalled
    bus2.rsp_ready = 1'b0;
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = 16'd30;
    tick();
    bus2.req_valid = 1'b0;
    tick();
    #1;
    chk("stall_v", bus2.rsp_valid, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_v", bus2.rsp_valid, 32'd0);
    chk("arst_d", bus2.rsp_rdata, 32'd0);
    bus2.rsp_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    wait_boot("reboot1");

    // Reset while a read is in its first stage
    bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = 16'd30;
    tick();
    bus2.req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("fl_v", bus2.rsp_valid, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    seen = bus2.rsp_valid;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | bus2.rsp_valid;
    end
    chk("fl_norsp", seen, 32'd0);
    wait_boot("reboot2");
    rd2("l2_after_rst", 16'd30, 16'h0045, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
